// File: rtl/led_run_ctrl.sv
// Running-light sequencer: turns debounced key presses into mode/speed/pause
// control and steps the 8-bit LED pattern on a speed-scaled prescaler tick.
module led_run_ctrl #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_speed,
    input  logic       key_pause,
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic [1:0] speed,
    output logic       running
);

    typedef enum logic [1:0] {
        MODE_LEFT   = 2'd0,
        MODE_RIGHT  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FLASH  = 2'd3
    } mode_e;

    localparam logic [23:0] DIV = 24'(TICK_DIV);

    // Key order in the packed vectors: {mode, speed, pause}.
    logic [2:0]  key_q, key_d;
    mode_e       mode_q, mode_d;
    logic [1:0]  speed_q, speed_d;
    logic        running_q, running_d;
    logic [7:0]  led_q, led_d;
    logic        dir_left_q, dir_left_d;
    logic [23:0] cnt_q, cnt_d;

    logic [2:0]  key_now;
    logic [2:0]  press;
    logic [23:0] period;
    logic        tick;
    mode_e       mode_next;

    function automatic logic [7:0] init_pattern(input mode_e m);
        case (m)
            MODE_LEFT:   return 8'h01;
            MODE_RIGHT:  return 8'h80;
            MODE_BOUNCE: return 8'h01;
            default:     return 8'hFF;
        endcase
    endfunction

    assign key_now   = {key_mode, key_speed, key_pause};
    assign press     = key_q & ~key_now;
    assign period    = DIV >> speed_q;
    assign tick      = running_q && (cnt_q == period - 24'd1);
    assign mode_next = mode_e'(2'(mode_q + 2'd1));

    always_comb begin
        // NOTE: every _d gets its current value first so no path leaves it unassigned (no latches).
        key_d      = key_now;
        mode_d     = mode_q;
        speed_d    = speed_q;
        running_d  = running_q;
        led_d      = led_q;
        dir_left_d = dir_left_q;
        cnt_d      = cnt_q;

        if (tick) begin
            case (mode_q)
                MODE_LEFT:  led_d = {led_q[6:0], led_q[7]};
                MODE_RIGHT: led_d = {led_q[0], led_q[7:1]};
                MODE_BOUNCE: begin
                    if (dir_left_q) begin
                        if (led_q == 8'h80) begin
                            dir_left_d = 1'b0;
                            led_d      = 8'h40;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end else begin
                        if (led_q == 8'h01) begin
                            dir_left_d = 1'b1;
                            led_d      = 8'h02;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                end
                default: led_d = ~led_q;
            endcase
        end

        if (running_q) begin
            cnt_d = tick ? 24'd0 : cnt_q + 24'd1;
        end

        // A mode press overrides any step computed above on the same cycle.
        if (press[2]) begin
            mode_d     = mode_next;
            led_d      = init_pattern(mode_next);
            dir_left_d = 1'b1;
            cnt_d      = 24'd0;
        end

        if (press[1]) begin
            speed_d = speed_q + 2'd1;
            cnt_d   = 24'd0;
        end

        if (press[0]) begin
            running_d = ~running_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q      <= 3'b111;
            mode_q     <= MODE_LEFT;
            speed_q    <= 2'd0;
            running_q  <= 1'b1;
            led_q      <= 8'h01;
            dir_left_q <= 1'b1;
            cnt_q      <= 24'd0;
        end else begin
            key_q      <= key_d;
            mode_q     <= mode_d;
            speed_q    <= speed_d;
            running_q  <= running_d;
            led_q      <= led_d;
            dir_left_q <= dir_left_d;
            cnt_q      <= cnt_d;
        end
    end

    assign led     = led_q;
    assign mode    = mode_q;
    assign speed   = speed_q;
    assign running = running_q;

endmodule

// File: tb/tb_led_run_ctrl.sv
// Bench for led_run_ctrl: directed and random key activity compared every cycle
// against a position-based model of the running light.
module tb_led_run_ctrl;

    localparam int TD = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_mode = 1'b1;
    logic       key_speed = 1'b1;
    logic       key_pause = 1'b1;
    logic [7:0] led;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       running;

    int n_cmp = 0;
    int n_err = 0;

    led_run_ctrl #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_mode  (key_mode),
        .key_speed (key_speed),
        .key_pause (key_pause),
        .led       (led),
        .mode      (mode),
        .speed     (speed),
        .running   (running)
    );

    always #5 clk = ~clk;

    // Model: the lit LED is tracked as a position 0..7 (FLASH as on/off),
    // the prescaler as clocks elapsed since the last step or clear.
    int   m_mode, m_speed, m_pos, m_elapsed;
    bit   m_run, m_bleft, m_flash_on;
    logic [2:0] m_kd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int m_period();
        return TD >> m_speed;
    endfunction

    function automatic logic [7:0] m_led();
        if (m_mode == 3) return m_flash_on ? 8'hFF : 8'h00;
        return 8'(1 << m_pos);
    endfunction

    task automatic m_reset();
        m_mode = 0; m_speed = 0; m_run = 1; m_pos = 0; m_bleft = 1;
        m_flash_on = 1; m_elapsed = 0; m_kd = 3'b111;
    endtask

    function automatic bit m_tick_next();
        return m_run && (m_elapsed + 1 == m_period());
    endfunction

    task automatic m_clock(input logic [2:0] k);
        logic [2:0] pr;
        bit tk;
        pr = m_kd & ~k;
        tk = m_tick_next();
        if (m_run) m_elapsed = tk ? 0 : m_elapsed + 1;
        if (tk) begin
            case (m_mode)
                0: m_pos = (m_pos + 1) % 8;
                1: m_pos = (m_pos + 7) % 8;
                2: begin
                    if (m_bleft) begin
                        if (m_pos == 7) begin m_bleft = 0; m_pos = 6; end
                        else m_pos++;
                    end else begin
                        if (m_pos == 0) begin m_bleft = 1; m_pos = 1; end
                        else m_pos--;
                    end
                end
                default: m_flash_on = !m_flash_on;
            endcase
        end
        if (pr[2]) begin
            m_mode = (m_mode + 1) % 4;
            m_pos = (m_mode == 1) ? 7 : 0;
            m_bleft = 1;
            m_flash_on = 1;
            m_elapsed = 0;
        end
        if (pr[1]) begin
            m_speed = (m_speed + 1) % 4;
            m_elapsed = 0;
        end
        if (pr[0]) m_run = !m_run;
        m_kd = k;
    endtask

    task automatic compare_all();
        check("led", 32'(led), 32'(m_led()));
        check("mode", 32'(mode), 32'(m_mode));
        check("speed", 32'(speed), 32'(m_speed));
        check("running", 32'(running), 32'(m_run));
    endtask

    // Called at a negedge; drives keys, advances one clock, compares at the next negedge.
    task automatic cycle(input logic km, input logic ks, input logic kp);
        key_mode = km; key_speed = ks; key_pause = kp;
        @(posedge clk);
        m_clock({km, ks, kp});
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b1);
    endtask

    task automatic press_mode();  cycle(1'b0, 1'b1, 1'b1); endtask
    task automatic press_speed(); cycle(1'b1, 1'b0, 1'b1); endtask
    task automatic press_pause(); cycle(1'b1, 1'b1, 1'b0); endtask

    initial begin
        m_reset();
        #12;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // LEFT stepping through a full rotation.
        idle(140);

        // Speed presses: periods 8, 4, 2, 16.
        for (int i = 0; i < 4; i++) begin
            press_speed();
            idle(40);
        end

        // Mode cycling: RIGHT, BOUNCE, FLASH, LEFT.
        for (int i = 0; i < 4; i++) begin
            press_mode();
            idle(50);
        end

        // BOUNCE across both end-stops.
        press_mode();
        press_mode();
        idle(300);

        // Pause mid-count, hold 100 clocks, resume.
        idle(7);
        press_pause();
        idle(100);
        press_pause();
        idle(40);

        // Mode press landing exactly on the tick cycle.
        for (int r = 0; r < 3; r++) begin
            int guard;
            guard = 0;
            while (!m_tick_next() && guard < 64) begin
                cycle(1'b1, 1'b1, 1'b1);
                guard++;
            end
            check("tick_align", 32'(m_tick_next()), 32'd1);
            press_mode();
            idle(20);
        end

        // Speed key held low for 1000 cycles counts once.
        for (int i = 0; i < 1000; i++) cycle(1'b1, 1'b0, 1'b1);
        idle(30);

        // Random key traffic, mostly released.
        for (int i = 0; i < 3000; i++) begin
            cycle(logic'($urandom_range(0, 19) != 0),
                  logic'($urandom_range(0, 19) != 0),
                  logic'($urandom_range(0, 29) != 0));
        end
        if (!m_run) press_pause();
        idle(20);

        // Asynchronous reset while in FLASH.
        while (m_mode != 3) begin
            press_mode();
            idle(3);
        end
        idle(25);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
